ksw_h_tracker: RTL
==================

# ksw_h_tracker

Consumes the per-diagonal 128-bit score-difference vectors (16 signed int8 lanes) that `loop_2` writes into its `v` array, one vector per cycle. It reconstructs absolute H scores by running prefix summation from a seed score and reports the maximum H, its cell index and the final H. It sits downstream of `loop_2` in the ksw extension datapath and provides the max-score and z-drop inputs for the next anti-diagonal step.

## Interface
- LANES, 16, int8 lanes per vector
- LW, 8, lane width (signed)
- HW, 32, absolute score width (signed)
- TW, 10, vector index width (matches `t`)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches `h0`, `st`, `en`
- h0  in  HW  signed seed score H before lane 0 of vector `st`
- st  in  TW  first vector index (inclusive)
- en  in  TW  last vector index (inclusive)
- in_valid  in  1  `in_v` holds the next vector
- in_ready  out  1  tracker accepts a beat this cycle
- in_v  in  LANES*LW  difference vector; lane k = bits [8k+7:8k], lane 0 = lowest cell
- busy  out  1  high from the cycle after an accepted `start` until `done`
- done  out  1  one-cycle pulse; results valid
- max_h  out  HW  maximum reconstructed H
- max_j  out  TW+4  cell index of `max_h` = vector_index*16 + lane
- last_h  out  HW  H after the last lane of vector `en`

## Operation
- States: IDLE, RUN, FIN.
- IDLE: `in_ready`=0. On `start`, latch the inputs:
  - `acc`=h0, `max_h`=h0, `max_j`=all-ones (seed marker), `cnt`=st.
  - If en ≥ st, go to RUN. If en < st, go to FIN with no beats.
- RUN: `in_ready`=1. On each beat (`in_valid`&`in_ready`):
  - H_k = acc + Σ_{i≤k} sext(lane_i), for k=0..15.
  - Candidate = largest H_k. Ties go to the lowest k.
  - If candidate > `max_h` (strictly greater), update `max_h` and set `max_j`={cnt,k}. Earlier cells win ties across beats.
  - `acc` ← H_15 and `cnt` ← cnt+1.
  - A beat with cnt==en is the last; go to FIN.
  - With `in_valid`=0, hold all state.
- FIN: one cycle. `done`=1, `last_h`=acc, then go to IDLE.
- Outputs `max_h`, `max_j` and `last_h` hold their values until the next accepted `start`.
- `start` while in RUN or FIN is ignored.
- `start` in IDLE on the cycle after `done` is legal (back-to-back diagonals).
- Arithmetic:
  - Lanes are sign-extended to HW. All sums are HW-bit two's complement.
  - Wrap-around is not detected. Upstream guarantees |H| < 2^(HW-1).
  - `cnt` is TW bits. An index range never crosses 2^TW-1, so en=1023 is the maximum.
- Reset (any state, including mid-RUN):
  - State → IDLE.
  - `in_ready`=0, `busy`=0, `done`=0, `max_h`=0, `max_j`=0, `last_h`=0.
  - Any partially accepted diagonal is discarded.

## Timing
- Throughput: 1 vector/cycle while `in_valid` is held high.
- `in_ready` rises the cycle after `start` is sampled. It falls the cycle after the last beat.
- `done` is asserted exactly 1 cycle after the last beat; results are registered on that same edge.
- Latency from `start` to `done`:
  - With in_valid held high: en-st+2 cycles.
  - For en<st: 2 cycles.
- `busy` is high on every RUN and FIN cycle.
- `in_ready` is not combinationally dependent on `in_valid`.
- The 16-lane prefix sum and max are single-cycle combinational. Implementation may tree them but must keep one-beat throughput.

## Test plan
- Basic: h0=10, st=0, en=0, in_v lanes all +1 (0x0101…01) → done 2 cycles after start, max_h=26, max_j=15, last_h=26.
- Declining: h0=100, st=3, en=4, both vectors all 0xFA (−6) → max_h=100, max_j=all-ones, last_h=100−192=−92, done after 3 cycles.
- Tie and cross-beat: h0=0, st=0, en=1, vector0 lane0=+5 and lane1=−5 (rest 0), vector1 lane0=+5 → max_h=5, max_j=0 (earliest tie wins), last_h=5.
- Backpressure: same as basic but with en=2 and `in_valid` toggled 1,0,0,1,0,1 → state held during gaps, 3 beats accepted, done 1 cycle after the 3rd, results identical to the gap-free run.
- Empty range: st=5, en=4, h0=−7 → done 2 cycles after start, max_h=−7, max_j=all-ones, last_h=−7, in_ready never high.
- Reset mid-RUN: start with st=0, en=9, assert rst after 4 beats → next cycle all outputs 0 and state IDLE. A fresh start then runs the basic case correctly, and `done` is never pulsed for the aborted run.

Source files
------------

// File: rtl/ksw_h_tracker_if.sv
// ksw_h_tracker_if
// Groups the control, vector stream and result signals of ksw_h_tracker.
//   master : the producer side (issues start/h0/st/en, streams in_v, reads results)
//   slave  : the tracker itself
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready never depends combinationally on in_valid.
// The producer holds in_v stable while in_valid is high and in_ready is low.
interface ksw_h_tracker_if #(
    parameter int LANES = 16,
    parameter int LW    = 8,
    parameter int HW    = 32,
    parameter int TW    = 10
);
    logic                  start;
    logic signed [HW-1:0]  h0;
    logic [TW-1:0]         st;
    logic [TW-1:0]         en;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*LW-1:0]   in_v;
    logic                  busy;
    logic                  done;
    logic signed [HW-1:0]  max_h;
    logic [TW+3:0]         max_j;
    logic signed [HW-1:0]  last_h;

    modport master (
        output start, h0, st, en, in_valid, in_v,
        input  in_ready, busy, done, max_h, max_j, last_h
    );

    modport slave (
        input  start, h0, st, en, in_valid, in_v,
        output in_ready, busy, done, max_h, max_j, last_h
    );
endinterface

// File: rtl/ksw_h_tracker.sv
// ksw_h_tracker
// Rebuilds absolute H scores from per-diagonal int8 difference vectors by
// prefix summation from a seed score, and tracks the maximum H, its cell
// index (vector_index*16 + lane) and the H after the final lane.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       ksw_h_tracker_if.slave (start/h0/st/en, in_valid/in_ready/in_v,
//             busy/done/max_h/max_j/last_h)
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 FIN)
module ksw_h_tracker #(
    parameter int LANES = 16,
    parameter int LW    = 8,
    parameter int HW    = 32,
    parameter int TW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    ksw_h_tracker_if.slave   bus,
    output logic [1:0]       dbg_state
);
    localparam int KW = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [HW-1:0] acc_q;
    logic signed [HW-1:0] max_h_q;
    logic [TW+KW-1:0]     max_j_q;
    logic signed [HW-1:0] last_h_q;
    logic [TW-1:0]        cnt_q;
    logic [TW-1:0]        en_q;
    // Empty range (en < st): RUN is passed through for one cycle with
    // in_ready held low, so done lands two cycles after start like a
    // single-vector diagonal.
    logic                 empty_q;

    logic                 beat;
    logic signed [HW-1:0] sum;
    logic signed [HW-1:0] best_h;
    logic [KW-1:0]        best_k;

    function automatic logic signed [HW-1:0] sext(input logic [LW-1:0] x);
        return {{(HW-LW){x[LW-1]}}, x};
    endfunction

    // Lane-by-lane prefix sum and argmax over the incoming vector. Strict
    // greater-than keeps the lowest lane on ties.
    always_comb begin
        sum    = acc_q;
        best_h = '0;
        best_k = '0;
        for (int k = 0; k < LANES; k++) begin
            sum = sum + sext(bus.in_v[k*LW +: LW]);
            if (k == 0 || sum > best_h) begin
                best_h = sum;
                best_k = KW'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        beat         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                bus.busy     = 1'b1;
                bus.in_ready = !empty_q;
                beat         = bus.in_valid && !empty_q;
                if (empty_q) state_d = FIN;
                else if (beat && cnt_q == en_q) state_d = FIN;
            end
            FIN: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            max_h_q  <= '0;
            max_j_q  <= '0;
            last_h_q <= '0;
            cnt_q    <= '0;
            en_q     <= '0;
            empty_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.start) begin
                acc_q    <= bus.h0;
                max_h_q  <= bus.h0;
                max_j_q  <= '1;          // seed marker: no cell beat h0
                last_h_q <= bus.h0;
                cnt_q    <= bus.st;
                en_q     <= bus.en;
                empty_q  <= (bus.en < bus.st);
            end
            if (beat) begin
                acc_q    <= sum;
                last_h_q <= sum;
                cnt_q    <= cnt_q + 1'b1;
                // Earlier beats keep ties because only strictly larger wins.
                if (best_h > max_h_q) begin
                    max_h_q <= best_h;
                    max_j_q <= {cnt_q, best_k};
                end
            end
        end
    end

    assign bus.max_h  = max_h_q;
    assign bus.max_j  = max_j_q;
    assign bus.last_h = last_h_q;
    assign dbg_state  = state_q;
endmodule
